// File: rtl/rf_multiport.sv
// Multi-port register file: combinational reads, priority-resolved writes, IP and flags registers.
// Latency: reads 0 cycles (optional same-cycle write bypass), writes visible after the capturing edge.
// Backpressure: none; every enabled write is accepted, and colliding writes resolve to the highest port.
module rf_multiport #(
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned WORD_WIDTH    = 32,
    parameter int unsigned RD_PORTS      = 10,
    parameter int unsigned WR_PORTS      = 4,
    parameter int unsigned IP_INDEX      = 31,
    parameter logic [WORD_WIDTH-1:0] IP_STEP  = WORD_WIDTH'(4),
    parameter logic [WORD_WIDTH-1:0] RESET_IP = '0,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b0
) (
    input  logic                                    clk_i,
    input  logic                                    arst_ni,
    input  logic [RD_PORTS-1:0][ADDRESS_WIDTH-1:0]  rd_sel_i,
    output logic [RD_PORTS-1:0][WORD_WIDTH-1:0]     rd_data_o,
    input  logic [WR_PORTS-1:0][ADDRESS_WIDTH-1:0]  wr_sel_i,
    input  logic [WR_PORTS-1:0][WORD_WIDTH-1:0]     wr_data_i,
    input  logic [WR_PORTS-1:0]                     wr_en_i,
    input  logic                                    ip_advance_i,
    output logic [WORD_WIDTH-1:0]                   ip_o,
    input  logic [WORD_WIDTH-1:0]                   flags_i,
    input  logic [WORD_WIDTH-1:0]                   flags_we_i,
    output logic [WORD_WIDTH-1:0]                   flags_o,
    output logic                                    conflict_o
);
    localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;

    if (IP_INDEX >= DEPTH) begin : g_bad_ip_index
        $error("rf_multiport: IP_INDEX must be below the register depth");
    end
    if (ZERO_REG && IP_INDEX == 0) begin : g_bad_ip_zero
        $error("rf_multiport: IP_INDEX cannot alias the hard-wired zero register");
    end
    if (RD_PORTS < 1 || WR_PORTS < 1) begin : g_bad_ports
        $error("rf_multiport: at least one read and one write port are required");
    end

    logic [DEPTH-1:0][WORD_WIDTH-1:0] regs_q;
    logic [DEPTH-1:0][WORD_WIDTH-1:0] regs_d;
    logic [DEPTH-1:0][WORD_WIDTH-1:0] wr_val;
    logic [DEPTH-1:0]                 wr_hit;
    logic [WORD_WIDTH-1:0]            flags_q;
    logic                             conflict_q;
    logic                             conflict_d;

    // Ascending port scan: a later (higher) port overwrites an earlier one, giving it priority.
    always_comb begin
        wr_hit = '0;
        wr_val = '0;
        for (int p = 0; p < WR_PORTS; p++) begin
            if (wr_en_i[p]) begin
                wr_hit[wr_sel_i[p]] = 1'b1;
                wr_val[wr_sel_i[p]] = wr_data_i[p];
            end
        end
    end

    // Writes to the zero register still collide, so it is not excluded here.
    always_comb begin
        conflict_d = 1'b0;
        for (int p = 0; p < WR_PORTS; p++) begin
            for (int q = p + 1; q < WR_PORTS; q++) begin
                if (wr_en_i[p] && wr_en_i[q] && (wr_sel_i[p] == wr_sel_i[q])) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_hit[i]) begin
                regs_d[i] = wr_val[i];
            end
        end
        // An explicit IP write takes precedence over the auto-advance.
        if (!wr_hit[IP_INDEX] && ip_advance_i) begin
            regs_d[IP_INDEX] = regs_q[IP_INDEX] + IP_STEP;
        end
        if (ZERO_REG) begin
            regs_d[0] = '0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            regs_q           <= '0;
            regs_q[IP_INDEX] <= RESET_IP;
            flags_q          <= '0;
            conflict_q       <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            flags_q    <= (flags_q & ~flags_we_i) | (flags_i & flags_we_i);
            conflict_q <= conflict_d;
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < RD_PORTS; k++) begin
            rd_data_o[k] = regs_q[rd_sel_i[k]];
            if (BYPASS && wr_hit[rd_sel_i[k]]) begin
                rd_data_o[k] = wr_val[rd_sel_i[k]];
            end
            if (ZERO_REG && (rd_sel_i[k] == '0)) begin
                rd_data_o[k] = '0;
            end
        end
    end

    assign ip_o       = regs_q[IP_INDEX];
    assign flags_o    = flags_q;
    assign conflict_o = conflict_q;

endmodule
